// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds the CHK state
// (one trailing XOR checksum byte after the payload).
package imem_pkg;

   // Width of the big-endian word-count header
   localparam int HDR_W = 16;

   // Word returned for unloaded, out-of-range or not-yet-running fetches
   localparam logic [31:0] NOP_WORD_DEFAULT = 32'hff000000;

   typedef enum logic [2:0] {
      HDR0  = 3'd0,
      HDR1  = 3'd1,
      WORDS = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK   = 3'd3,
`endif
      RUN   = 3'd4,
      ERR   = 3'd5
   } imem_state_t;

endpackage

// File: rtl/imem_word_ram.sv
// DEPTH_WORDS x 32 instruction store: synchronous write, registered read,
// plus one valid bit per word so unwritten words can be reported as empty
// without a clearing sweep. Only the valid bits are reset; the data array
// stays resetless so it maps onto block RAM.
module imem_word_ram #(
   parameter int DEPTH_WORDS = 64,
   parameter int AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [31:0]   wr_data,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output logic [31:0]   rd_data,
   output logic          rd_valid
);

   logic [31:0]            mem [DEPTH_WORDS];
   logic [DEPTH_WORDS-1:0] valid_bits;

   // Data array write and registered read (no reset so it infers block RAM)
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

   // Per-word valid bits and the registered valid flag of the last read
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_bits <= '0;
         rd_valid   <= 1'b0;
      end else begin
         if (wr_en) begin
            valid_bits[wr_addr] <= 1'b1;
         end
         if (rd_en) begin
            rd_valid <= valid_bits[rd_addr];
         end
      end
   end

endmodule

// File: rtl/imem_loader_server.sv
// Boot loader + instruction server. A byte stream (16-bit big-endian word
// count, then big-endian 32-bit words) fills the instruction RAM while the
// CPU is held; once the load completes the CPU is released and fetches are
// served with one cycle of latency.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN -- expect one trailing
// byte equal to the XOR of all payload bytes before entering RUN.
module imem_loader_server
   import imem_pkg::*;
#(
   parameter int          DEPTH_WORDS = 64,
   parameter logic [31:0] NOP_WORD    = NOP_WORD_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] fetch_addr_i,
   input  logic        fetch_en_i,
   output logic [31:0] instruction_o,
   input  logic [7:0]  load_byte_i,
   input  logic        load_valid_i,
   output logic        load_ready_o,
   output logic        cpu_hold_o,
   output logic        load_err_o
);

   localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   imem_state_t      state;
   logic [HDR_W-1:0] count_reg;
   logic [HDR_W-1:0] ptr_reg;
   logic [1:0]       byte_idx_reg;
   logic [23:0]      asm_reg;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]       csum_reg;
`endif
   logic             hit_reg;

   logic [HDR_W-1:0] hdr_count;
   logic             hdr_bad;
   logic             last_word;
   logic             in_range;
   logic             wr_en;
   logic [31:0]      wr_data;
   logic             rd_en;
   logic [31:0]      rd_data;
   logic             rd_valid;

   // Header decode: count_reg already holds the high byte while in HDR1
   assign hdr_count = {count_reg[HDR_W-1:8], load_byte_i};
   assign hdr_bad   = (hdr_count == '0) || (32'(hdr_count) > 32'(DEPTH_WORDS));
   assign last_word = (ptr_reg == count_reg - HDR_W'(1));

   // The 4th byte of a word completes it and is written on the same edge
   assign wr_en   = (state == WORDS) && load_valid_i && (byte_idx_reg == 2'd3);
   assign wr_data = {asm_reg, load_byte_i};

   // Addresses never wrap: anything at or above DEPTH_WORDS is a miss
   assign in_range = (fetch_addr_i < 32'(DEPTH_WORDS));
   assign rd_en    = (state == RUN) && fetch_en_i && in_range;

   imem_word_ram #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_ram (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en),
      .wr_addr  (ptr_reg[AW-1:0]),
      .wr_data  (wr_data),
      .rd_en    (rd_en),
      .rd_addr  (fetch_addr_i[AW-1:0]),
      .rd_data  (rd_data),
      .rd_valid (rd_valid)
   );

   // Load FSM with registered handshake/status outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= HDR0;
         count_reg    <= '0;
         ptr_reg      <= '0;
         byte_idx_reg <= 2'd0;
         asm_reg      <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_reg     <= 8'd0;
`endif
         load_ready_o <= 1'b1;
         cpu_hold_o   <= 1'b1;
         load_err_o   <= 1'b0;
      end else begin
         case (state)
            HDR0: begin
               if (load_valid_i) begin
                  count_reg[HDR_W-1:8] <= load_byte_i;
                  state                <= HDR1;
               end
            end
            HDR1: begin
               if (load_valid_i) begin
                  if (hdr_bad) begin
                     state        <= ERR;
                     load_ready_o <= 1'b0;
                     load_err_o   <= 1'b1;
                  end else begin
                     count_reg    <= hdr_count;
                     ptr_reg      <= '0;
                     byte_idx_reg <= 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                     csum_reg     <= 8'd0;
`endif
                     state        <= WORDS;
                  end
               end
            end
            WORDS: begin
               if (load_valid_i) begin
                  asm_reg      <= {asm_reg[15:0], load_byte_i};
                  byte_idx_reg <= byte_idx_reg + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  csum_reg     <= csum_reg ^ load_byte_i;
`endif
                  if (byte_idx_reg == 2'd3) begin
                     ptr_reg <= ptr_reg + HDR_W'(1);
                     if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state        <= CHK;
`else
                        state        <= RUN;
                        load_ready_o <= 1'b0;
                        cpu_hold_o   <= 1'b0;
`endif
                     end
                  end
               end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK: begin
               if (load_valid_i) begin
                  load_ready_o <= 1'b0;
                  if (load_byte_i == csum_reg) begin
                     state      <= RUN;
                     cpu_hold_o <= 1'b0;
                  end else begin
                     state      <= ERR;
                     load_err_o <= 1'b1;
                  end
               end
            end
`endif
            RUN: begin
            end
            ERR: begin
            end
            default: begin
               state        <= ERR;
               load_ready_o <= 1'b0;
               cpu_hold_o   <= 1'b1;
               load_err_o   <= 1'b1;
            end
         endcase
      end
   end

   // Remember whether the last RUN fetch hit the array; held when fetch_en_i is low
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hit_reg <= 1'b0;
      end else if ((state == RUN) && fetch_en_i) begin
         hit_reg <= in_range;
      end
   end

   // Output is selected purely from registered RAM data and registered flags
   assign instruction_o = (hit_reg && rd_valid) ? rd_data : NOP_WORD;

endmodule

// File: tb/tb_imem_loader_server.sv
// Randomized self-checking bench for imem_loader_server. A byte-history
// model derives the expected load phase, RAM image and fetch results from
// the stream rules; a negedge process compares every output every cycle.
// Honours IMEM_LOADER_CHECKSUM_EN (trailing XOR byte) when defined.
module tb_imem_loader_server;

   localparam int          DEPTH = 64;
   localparam logic [31:0] NOP   = 32'hff000000;
`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam int CSUM = 1;
`else
   localparam int CSUM = 0;
`endif
   localparam int P_LOAD = 0;
   localparam int P_RUN  = 1;
   localparam int P_ERR  = 2;

   logic        clk;
   logic        rst;
   logic [31:0] fetch_addr;
   logic        fetch_en;
   logic [31:0] instruction;
   logic [7:0]  load_byte;
   logic        load_valid;
   logic        load_ready;
   logic        cpu_hold;
   logic        load_err;

   imem_loader_server #(
      .DEPTH_WORDS (DEPTH),
      .NOP_WORD    (NOP)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .fetch_addr_i  (fetch_addr),
      .fetch_en_i    (fetch_en),
      .instruction_o (instruction),
      .load_byte_i   (load_byte),
      .load_valid_i  (load_valid),
      .load_ready_o  (load_ready),
      .cpu_hold_o    (cpu_hold),
      .load_err_o    (load_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- behavioural model ----------------
   bit [7:0]    rx[$];          // every byte the loader should have accepted since reset
   logic [31:0] exp_instr;

   function automatic int hdr_n();
      return int'({rx[0], rx[1]});
   endfunction

   // Phase implied purely by the accepted-byte history
   function automatic int phase_of();
      int n;
      bit [7:0] x;
      if (rx.size() < 2) return P_LOAD;
      n = hdr_n();
      if (n == 0 || n > DEPTH) return P_ERR;
      if (rx.size() < 2 + 4 * n + CSUM) return P_LOAD;
      if (CSUM == 0) return P_RUN;
      x = 8'd0;
      for (int i = 2; i < 2 + 4 * n; i++) x ^= rx[i];
      return (x == rx[2 + 4 * n]) ? P_RUN : P_ERR;
   endfunction

   function automatic logic [31:0] word_of(input int a);
      return {rx[2 + 4 * a], rx[3 + 4 * a], rx[4 + 4 * a], rx[5 + 4 * a]};
   endfunction

   // Model update on each clock edge; reset wipes the accepted history
   always @(posedge clk or posedge rst) begin
      int ph;
      if (rst) begin
         rx.delete();
         exp_instr = NOP;
      end else begin
         ph = phase_of();
         if (ph == P_RUN && fetch_en) begin
            if (fetch_addr < 32'(DEPTH) && fetch_addr < 32'(hdr_n()))
               exp_instr = word_of(int'(fetch_addr));
            else
               exp_instr = NOP;
         end
         if (ph == P_LOAD && load_valid) rx.push_back(load_byte);
      end
   end

   // ---------------- comparison ----------------
   int    n_cmp = 0;
   int    n_bad = 0;
   bit    lit_on = 1'b0;
   int    lit_sel = 0;
   logic [31:0] lit_exp = '0;
   string lit_name = "";

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Single compare process: model checks every cycle plus literal pins on request
   always @(negedge clk) begin
      int ph;
      if (!rst) begin
         ph = phase_of();
         chk("instruction", instruction, exp_instr);
         chk("cpu_hold", 32'(cpu_hold), 32'(ph != P_RUN));
         chk("load_ready", 32'(load_ready), 32'(ph == P_LOAD));
         chk("load_err", 32'(load_err), 32'(ph == P_ERR));
         if (lit_on) begin
            case (lit_sel)
               0: chk(lit_name, instruction, lit_exp);
               1: chk(lit_name, 32'(cpu_hold), lit_exp);
               2: chk(lit_name, 32'(load_ready), lit_exp);
               default: chk(lit_name, 32'(load_err), lit_exp);
            endcase
         end
      end
   end

   // ---------------- stimulus ----------------
   bit [7:0]    stream[$];
   logic [31:0] words[$];
   bit          rnd_fetch = 1'b0;
   int          cur_n = 1;

   function automatic logic [31:0] rand_addr();
      case ($urandom_range(0, 3))
         0: return 32'($urandom_range(0, cur_n + 2));
         1: return 32'($urandom_range(0, DEPTH - 1));
         2: return 32'($urandom_range(DEPTH, DEPTH + 3));
         default: return $urandom;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      if (rnd_fetch) begin
         fetch_en   = 1'($urandom_range(0, 1));
         fetch_addr = rand_addr();
      end
   endtask

   task automatic lit(input int sel, input logic [31:0] exp, input string name);
      lit_sel  = sel;
      lit_exp  = exp;
      lit_name = name;
      lit_on   = 1'b1;
      @(negedge clk);
      #1;
      lit_on = 1'b0;
   endtask

   task automatic do_reset();
      #2;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst        = 1'b0;
      fetch_en   = 1'b0;
      load_valid = 1'b0;
   endtask

   // Header value, then the first n_words of words[], then optional checksum
   task automatic build(input int hdr, input int n_words, input bit bad_csum);
      bit [7:0] x;
      stream.delete();
      stream.push_back(8'(hdr >> 8));
      stream.push_back(8'(hdr));
      x = 8'd0;
      for (int i = 0; i < n_words; i++) begin
         for (int b = 3; b >= 0; b--) begin
            stream.push_back(8'(words[i] >> (8 * b)));
            x ^= 8'(words[i] >> (8 * b));
         end
      end
      if (CSUM != 0) stream.push_back(bad_csum ? (x ^ 8'(1 + $urandom_range(0, 254))) : x);
   endtask

   task automatic send_byte(input bit [7:0] b, input int gap);
      load_valid = 1'b1;
      load_byte  = b;
      tick();
      load_valid = 1'b0;
      load_byte  = 8'($urandom);
      repeat (gap) tick();
   endtask

   task automatic send_stream(input int upto, input int mingap, input int maxgap);
      for (int i = 0; i < upto && i < stream.size(); i++)
         send_byte(stream[i], $urandom_range(mingap, maxgap));
   endtask

   task automatic fetch_lit(input logic [31:0] addr, input logic [31:0] exp, input string name);
      fetch_en   = 1'b1;
      fetch_addr = addr;
      @(posedge clk);
      #1;
      fetch_en   = 1'b0;
      fetch_addr = $urandom;
      lit(0, exp, name);
   endtask

   task automatic two_word_fetches(input string tag);
      fetch_lit(32'd0, 32'h20080005, {tag, "_addr0"});
      fetch_lit(32'd1, 32'hAC030003, {tag, "_addr1"});
      fetch_lit(32'd2, NOP, {tag, "_addr2_unloaded"});
   endtask

   initial begin
      int n, kind;
      rst        = 1'b1;
      fetch_en   = 1'b0;
      fetch_addr = '0;
      load_byte  = '0;
      load_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset state
      lit(1, 32'd1, "reset_hold");
      lit(2, 32'd1, "reset_ready");
      lit(3, 32'd0, "reset_err");
      lit(0, NOP, "reset_instr");

      // Two-word stream (payload XOR is 8'h81), back-to-back bytes
      words = '{32'h20080005, 32'hAC030003};
      cur_n = 2;
      build(2, 2, 1'b0);
      send_stream(stream.size() - 1, 0, 0);
      lit(1, 32'd1, "hold_before_last");
      send_stream_last();
      lit(1, 32'd0, "hold_after_last");
      lit(2, 32'd0, "ready_in_run");
      two_word_fetches("basic");
      fetch_lit(32'(DEPTH), NOP, "addr_depth_no_wrap");
      fetch_lit(32'hffffffff, NOP, "addr_max");
      lit(0, NOP, "hold_when_fetch_off");

      // Same stream with valid toggling 1-0-1
      do_reset();
      send_stream(stream.size(), 1, 1);
      two_word_fetches("toggled");

      // Abort after 5 payload bytes, then reload fully
      do_reset();
      send_stream(7, 0, 0);
      do_reset();
      send_stream(stream.size(), 0, 0);
      two_word_fetches("after_abort");

      // Zero count
      do_reset();
      build(0, 2, 1'b0);
      send_stream(stream.size(), 0, 0);
      lit(3, 32'd1, "zero_err");
      lit(1, 32'd1, "zero_hold");
      lit(2, 32'd0, "zero_ready");
      fetch_lit(32'd0, NOP, "zero_fetch");

      // Count one above depth
      do_reset();
      build(DEPTH + 1, 0, 1'b0);
      send_stream(stream.size(), 0, 0);
      lit(3, 32'd1, "over_depth_err");

`ifdef IMEM_LOADER_CHECKSUM_EN
      // Wrong checksum byte
      do_reset();
      build(2, 2, 1'b0);
      stream[stream.size() - 1] = 8'h8D;
      send_stream(stream.size(), 0, 0);
      lit(3, 32'd1, "bad_csum_err");
      fetch_lit(32'd0, NOP, "bad_csum_fetch");
`endif

      // Full-depth load
      do_reset();
      words.delete();
      for (int i = 0; i < DEPTH; i++) words.push_back($urandom);
      cur_n = DEPTH;
      build(DEPTH, DEPTH, 1'b0);
      send_stream(stream.size(), 0, 0);
      fetch_lit(32'(DEPTH - 1), words[DEPTH - 1], "full_last_word");

      // Randomized loads, faults and fetches
      rnd_fetch = 1'b1;
      for (int it = 0; it < 25; it++) begin
         do_reset();
         kind = $urandom_range(0, 9);
         n = ($urandom_range(0, 3) == 0) ? DEPTH : $urandom_range(1, 16);
         words.delete();
         for (int i = 0; i < n; i++) words.push_back($urandom);
         cur_n = n;
         if (kind == 0) begin
            build(($urandom_range(0, 1) == 0) ? 0 : $urandom_range(DEPTH + 1, 65535), n, 1'b0);
         end else begin
            build(n, n, (CSUM != 0) && ($urandom_range(0, 3) == 0));
         end
         if (kind == 1) begin
            send_stream($urandom_range(1, stream.size() - 1), 0, 2);
            do_reset();
         end
         send_stream(stream.size(), 0, 2);
         for (int c = 0; c < 60; c++) begin
            load_valid = 1'($urandom_range(0, 1));
            load_byte  = 8'($urandom);
            tick();
         end
         load_valid = 1'b0;
      end
      rnd_fetch = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   task automatic send_stream_last();
      send_byte(stream[stream.size() - 1], 0);
   endtask

endmodule
